// File: rtl/decode_issue_stage_if.sv
// Signal bundle between fetch, the decode/issue stage and execute (slave = stage side).
interface decode_issue_stage_if #(
    parameter int NUM_SREG    = 32,
    parameter int NUM_VREG    = 32,
    parameter int MASK_W      = 4,
    parameter int STALL_CNT_W = 32
);
    localparam int SIDX_W = $clog2(NUM_SREG);
    localparam int VIDX_W = $clog2(NUM_VREG);

    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            in_inst;
    logic [31:0]            in_pc;
    logic                   in_r_read1;
    logic                   in_r_read2;
    logic                   in_v_read1;
    logic                   in_v_read2;
    logic                   in_reg_wr;
    logic                   in_vec_wr;
    logic                   in_store_pc;
    logic                   in_halt;

    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            out_inst;
    logic [31:0]            out_pc;
    logic [SIDX_W-1:0]      out_rd;
    logic [MASK_W-1:0]      out_mask;
    logic                   out_reg_wr;
    logic                   out_vec_wr;
    logic                   out_halt;

    logic                   swb_valid;
    logic [SIDX_W-1:0]      swb_idx;
    logic                   vwb_valid;
    logic [VIDX_W-1:0]      vwb_idx;
    logic                   flush;
    logic                   halted;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport slave (
        input  in_valid, in_inst, in_pc, in_r_read1, in_r_read2, in_v_read1, in_v_read2,
               in_reg_wr, in_vec_wr, in_store_pc, in_halt, out_ready,
               swb_valid, swb_idx, vwb_valid, vwb_idx, flush,
        output in_ready, out_valid, out_inst, out_pc, out_rd, out_mask,
               out_reg_wr, out_vec_wr, out_halt, halted, stall_cycles
    );

    modport master (
        output in_valid, in_inst, in_pc, in_r_read1, in_r_read2, in_v_read1, in_v_read2,
               in_reg_wr, in_vec_wr, in_store_pc, in_halt, out_ready,
               swb_valid, swb_idx, vwb_valid, vwb_idx, flush,
        input  in_ready, out_valid, out_inst, out_pc, out_rd, out_mask,
               out_reg_wr, out_vec_wr, out_halt, halted, stall_cycles
    );
endinterface

// File: rtl/decode_issue_stage.sv
// Registered decode/issue stage with scalar/vector scoreboards, halt latch, flush and stall counter.
// Optional macro SCOREBOARD_BYPASS_EN: a same-cycle writeback releases the hazard immediately.
module decode_issue_stage #(
    parameter int NUM_SREG    = 32,
    parameter int NUM_VREG    = 32,
    parameter int MASK_W      = 4,
    parameter int LINK_REG    = NUM_SREG - 1,
    parameter int STALL_CNT_W = 32
) (
    input logic                 clk,
    input logic                 rst,
    decode_issue_stage_if.slave bus
);
    localparam int SIDX_W = $clog2(NUM_SREG);
    localparam int VIDX_W = $clog2(NUM_VREG);
    localparam logic [SIDX_W-1:0]      LINK_IDX  = SIDX_W'(LINK_REG);
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    logic [SIDX_W-1:0]      src_s1, src_s2, dst_s;
    logic [VIDX_W-1:0]      src_v1, src_v2, dst_v, out_vrd;
    logic [NUM_SREG-1:0]    swb_mask, sbusy_chk;
    logic [NUM_VREG-1:0]    vwb_mask, vbusy_chk;
    logic                   s_hazard, v_hazard, hazard;
    logic                   in_ready, load, issue;

    logic                   out_valid_q, out_valid_d;
    logic [31:0]            out_inst_q, out_inst_d;
    logic [31:0]            out_pc_q, out_pc_d;
    logic [SIDX_W-1:0]      out_rd_q, out_rd_d;
    logic [MASK_W-1:0]      out_mask_q, out_mask_d;
    logic                   out_reg_wr_q, out_reg_wr_d;
    logic                   out_vec_wr_q, out_vec_wr_d;
    logic                   out_halt_q, out_halt_d;
    logic [NUM_SREG-1:0]    sbusy_q, sbusy_d;
    logic [NUM_VREG-1:0]    vbusy_q, vbusy_d;
    logic                   halted_q, halted_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    // Vector sources deliberately use the swapped field order (v_read1 -> rs2 field).
    assign src_s1  = bus.in_inst[15 +: SIDX_W];
    assign src_s2  = bus.in_inst[10 +: SIDX_W];
    assign dst_s   = bus.in_store_pc ? LINK_IDX : bus.in_inst[20 +: SIDX_W];
    assign src_v1  = bus.in_inst[10 +: VIDX_W];
    assign src_v2  = bus.in_inst[15 +: VIDX_W];
    assign dst_v   = bus.in_inst[20 +: VIDX_W];
    assign out_vrd = out_inst_q[20 +: VIDX_W];

    always_comb begin
        swb_mask = '0;
        vwb_mask = '0;
        if (bus.swb_valid) swb_mask[bus.swb_idx] = 1'b1;
        if (bus.vwb_valid) vwb_mask[bus.vwb_idx] = 1'b1;
`ifdef SCOREBOARD_BYPASS_EN
        sbusy_chk = sbusy_q & ~swb_mask;
        vbusy_chk = vbusy_q & ~vwb_mask;
`else
        sbusy_chk = sbusy_q;
        vbusy_chk = vbusy_q;
`endif
    end

    // A register is also in flight while its writer still sits in the output register.
    always_comb begin
        s_hazard = 1'b0;
        v_hazard = 1'b0;
        if (bus.in_r_read1 && (sbusy_chk[src_s1] ||
            (out_valid_q && out_reg_wr_q && out_rd_q == src_s1))) s_hazard = 1'b1;
        if (bus.in_r_read2 && (sbusy_chk[src_s2] ||
            (out_valid_q && out_reg_wr_q && out_rd_q == src_s2))) s_hazard = 1'b1;
        if (bus.in_reg_wr && (sbusy_chk[dst_s] ||
            (out_valid_q && out_reg_wr_q && out_rd_q == dst_s))) s_hazard = 1'b1;
        if (bus.in_v_read1 && (vbusy_chk[src_v1] ||
            (out_valid_q && out_vec_wr_q && out_vrd == src_v1))) v_hazard = 1'b1;
        if (bus.in_v_read2 && (vbusy_chk[src_v2] ||
            (out_valid_q && out_vec_wr_q && out_vrd == src_v2))) v_hazard = 1'b1;
        if (bus.in_vec_wr && (vbusy_chk[dst_v] ||
            (out_valid_q && out_vec_wr_q && out_vrd == dst_v))) v_hazard = 1'b1;
    end

    assign hazard   = s_hazard | v_hazard;
    assign in_ready = !halted_q && !hazard && (!out_valid_q || bus.out_ready);
    assign load     = bus.in_valid && in_ready && !bus.flush;
    assign issue    = out_valid_q && bus.out_ready && !bus.flush;

    // Scoreboard clears are applied before issue sets so a same-index set wins.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_inst_d   = out_inst_q;
        out_pc_d     = out_pc_q;
        out_rd_d     = out_rd_q;
        out_mask_d   = out_mask_q;
        out_reg_wr_d = out_reg_wr_q;
        out_vec_wr_d = out_vec_wr_q;
        out_halt_d   = out_halt_q;
        sbusy_d      = sbusy_q & ~swb_mask;
        vbusy_d      = vbusy_q & ~vwb_mask;
        halted_d     = halted_q;
        stall_d      = stall_q;

        if (issue) begin
            if (out_reg_wr_q) sbusy_d[out_rd_q] = 1'b1;
            if (out_vec_wr_q) vbusy_d[out_vrd] = 1'b1;
            if (out_halt_q) halted_d = 1'b1;
            out_valid_d = 1'b0;
        end

        if (load) begin
            out_valid_d  = 1'b1;
            out_inst_d   = bus.in_inst;
            out_pc_d     = bus.in_pc;
            out_rd_d     = dst_s;
            out_mask_d   = bus.in_inst[MASK_W-1:0];
            out_reg_wr_d = bus.in_reg_wr;
            out_vec_wr_d = bus.in_vec_wr;
            out_halt_d   = bus.in_halt;
        end

        if (bus.flush) out_valid_d = 1'b0;

        if (bus.in_valid && hazard && !halted_q && stall_q != STALL_MAX)
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_inst_q   <= '0;
            out_pc_q     <= '0;
            out_rd_q     <= '0;
            out_mask_q   <= '0;
            out_reg_wr_q <= 1'b0;
            out_vec_wr_q <= 1'b0;
            out_halt_q   <= 1'b0;
            sbusy_q      <= '0;
            vbusy_q      <= '0;
            halted_q     <= 1'b0;
            stall_q      <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_inst_q   <= out_inst_d;
            out_pc_q     <= out_pc_d;
            out_rd_q     <= out_rd_d;
            out_mask_q   <= out_mask_d;
            out_reg_wr_q <= out_reg_wr_d;
            out_vec_wr_q <= out_vec_wr_d;
            out_halt_q   <= out_halt_d;
            sbusy_q      <= sbusy_d;
            vbusy_q      <= vbusy_d;
            halted_q     <= halted_d;
            stall_q      <= stall_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_inst     = out_inst_q;
    assign bus.out_pc       = out_pc_q;
    assign bus.out_rd       = out_rd_q;
    assign bus.out_mask     = out_mask_q;
    assign bus.out_reg_wr   = out_reg_wr_q;
    assign bus.out_vec_wr   = out_vec_wr_q;
    assign bus.out_halt     = out_halt_q;
    assign bus.halted       = halted_q;
    assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed table-driven bench for decode_issue_stage, plus hand-written flush/halt/saturation sequences.
module tb_decode_issue_stage;
    localparam int STALL_CNT_W = 4;
`ifdef SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int SO = BYP ? 0 : 1;

    localparam logic [7:0] F_R1 = 8'h80, F_R2 = 8'h40, F_V1 = 8'h20, F_V2 = 8'h10;
    localparam logic [7:0] F_RW = 8'h08, F_VW = 8'h04, F_SP = 8'h02, F_HT = 8'h01;

    typedef struct {
        logic        iv;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [7:0]  fl;
        logic        ordy;
        logic        swv;
        logic [4:0]  swi;
        logic        vwv;
        logic [4:0]  vwi;
        logic        e_ir;
        logic        e_ov;
        logic [4:0]  e_rd;
        logic [31:0] e_pc;
        logic [3:0]  e_mask;
        int          e_st;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    vec_t tbl[19];

    always #5 clk = ~clk;

    decode_issue_stage_if #(.NUM_SREG(32), .NUM_VREG(32), .MASK_W(4), .STALL_CNT_W(STALL_CNT_W)) bus ();

    decode_issue_stage #(
        .NUM_SREG(32), .NUM_VREG(32), .MASK_W(4), .LINK_REG(31), .STALL_CNT_W(STALL_CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2, input int mask);
        logic [4:0] a, b, c;
        logic [3:0] m;
        a = 5'(rd);
        b = 5'(rs1);
        c = 5'(rs2);
        m = 4'(mask);
        return {7'd0, a, b, c, 6'd0, m};
    endfunction

    function automatic vec_t row(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                                 input logic [7:0] fl, input logic ordy, input logic swv,
                                 input logic [4:0] swi, input logic vwv, input logic [4:0] vwi,
                                 input logic ir, input logic ov, input logic [4:0] rd,
                                 input logic [31:0] opc, input logic [3:0] m, input int st);
        vec_t v;
        v.iv = iv; v.inst = inst; v.pc = pc; v.fl = fl; v.ordy = ordy;
        v.swv = swv; v.swi = swi; v.vwv = vwv; v.vwi = vwi;
        v.e_ir = ir; v.e_ov = ov; v.e_rd = rd; v.e_pc = opc; v.e_mask = m; v.e_st = st;
        return v;
    endfunction

    task automatic applyStimulus(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                                 input logic [7:0] fl, input logic ordy, input logic swv,
                                 input logic [4:0] swi, input logic vwv, input logic [4:0] vwi,
                                 input logic fls);
        bus.in_valid    = iv;
        bus.in_inst     = inst;
        bus.in_pc       = pc;
        bus.in_r_read1  = fl[7];
        bus.in_r_read2  = fl[6];
        bus.in_v_read1  = fl[5];
        bus.in_v_read2  = fl[4];
        bus.in_reg_wr   = fl[3];
        bus.in_vec_wr   = fl[2];
        bus.in_store_pc = fl[1];
        bus.in_halt     = fl[0];
        bus.out_ready   = ordy;
        bus.swb_valid   = swv;
        bus.swb_idx     = swi;
        bus.vwb_valid   = vwv;
        bus.vwb_idx     = vwi;
        bus.flush       = fls;
    endtask

    task automatic idle(input logic ordy, input logic fls);
        applyStimulus(1'b0, 32'd0, 32'd0, 8'd0, ordy, 1'b0, 5'd0, 1'b0, 5'd0, fls);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tbl[0]  = row(1, mk(3,1,0,5),    32'h100, F_R1|F_RW, 1, 0,0, 0,0, 1, 1, 3, 32'h100, 5, 0);
        tbl[1]  = row(1, mk(7,0,8,3),    32'h104, F_V1|F_VW, 1, 0,0, 0,0, 1, 1, 7, 32'h104, 3, 0);
        tbl[2]  = row(1, mk(9,7,0,1),    32'h108, F_V2|F_VW, 1, 0,0, 0,0, 0, 0, 7, 32'h104, 3, 1);
        tbl[3]  = row(1, mk(9,7,0,1),    32'h108, F_V2|F_VW, 1, 0,0, 0,0, 0, 0, 7, 32'h104, 3, 2);
        tbl[4]  = row(1, mk(9,7,0,1),    32'h108, F_V2|F_VW, 1, 0,0, 1,2, 0, 0, 7, 32'h104, 3, 3);
        tbl[5]  = row(1, mk(9,7,0,1),    32'h108, F_V2|F_VW, 1, 0,0, 1,7, BYP, BYP,
                      BYP ? 5'd9 : 5'd7, BYP ? 32'h108 : 32'h104, BYP ? 4'd1 : 4'd3, 3+SO);
        tbl[6]  = row(!BYP, mk(9,7,0,1), 32'h108, F_V2|F_VW, 0, 0,0, 0,0, !BYP, 1, 9, 32'h108, 1, 3+SO);
        tbl[7]  = row(1, mk(5,0,0,0),    32'h10C, F_SP|F_RW, 1, 0,0, 0,0, 1, 1, 31, 32'h10C, 0, 3+SO);
        tbl[8]  = row(1, mk(1,31,0,0),   32'h110, F_R1|F_RW, 0, 0,0, 0,0, 0, 1, 31, 32'h10C, 0, 4+SO);
        tbl[9]  = row(1, mk(1,31,0,0),   32'h110, F_R1|F_RW, 1, 0,0, 0,0, 0, 0, 31, 32'h10C, 0, 5+SO);
        tbl[10] = row(1, mk(1,31,0,0),   32'h110, F_R1|F_RW, 1, 1,3, 0,0, 0, 0, 31, 32'h10C, 0, 6+SO);
        tbl[11] = row(0, 32'd0,          32'h0,   8'd0,      1, 1,31, 0,0, 1, 0, 31, 32'h10C, 0, 6+SO);
        tbl[12] = row(1, mk(1,31,0,0),   32'h110, F_R1|F_RW, 1, 0,0, 0,0, 1, 1, 1, 32'h110, 0, 6+SO);
        tbl[13] = row(1, mk(10,11,12,2), 32'h114, F_R1|F_R2|F_RW, 0, 0,0, 0,0, 0, 1, 1, 32'h110, 0, 6+SO);
        tbl[14] = row(1, mk(10,11,12,2), 32'h114, F_R1|F_R2|F_RW, 0, 0,0, 0,0, 0, 1, 1, 32'h110, 0, 6+SO);
        tbl[15] = row(1, mk(10,11,12,2), 32'h114, F_R1|F_R2|F_RW, 0, 0,0, 0,0, 0, 1, 1, 32'h110, 0, 6+SO);
        tbl[16] = row(1, mk(10,11,12,2), 32'h114, F_R1|F_R2|F_RW, 1, 0,0, 0,0, 1, 1, 10, 32'h114, 2, 6+SO);
        tbl[17] = row(1, mk(12,13,14,0), 32'h118, F_R1|F_R2|F_RW, 1, 0,0, 0,0, 1, 1, 12, 32'h118, 0, 6+SO);
        tbl[18] = row(0, 32'd0,          32'h0,   8'd0,      1, 0,0, 0,0, 1, 0, 12, 32'h118, 0, 6+SO);

        // Reset state
        rst = 1'b1;
        idle(1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset out_valid", 32'(bus.out_valid), 0);
        checkOutput("reset in_ready", 32'(bus.in_ready), 1);
        checkOutput("reset halted", 32'(bus.halted), 0);
        checkOutput("reset stall", 32'(bus.stall_cycles), 0);
        checkOutput("reset out_rd", 32'(bus.out_rd), 0);
        checkOutput("reset out_pc", bus.out_pc, 0);

        for (int i = 0; i < 19; i++) begin
            applyStimulus(tbl[i].iv, tbl[i].inst, tbl[i].pc, tbl[i].fl, tbl[i].ordy,
                          tbl[i].swv, tbl[i].swi, tbl[i].vwv, tbl[i].vwi, 1'b0);
            #1;
            checkOutput($sformatf("row%0d in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_ir));
            tick();
            checkOutput($sformatf("row%0d out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_ov));
            checkOutput($sformatf("row%0d out_rd", i), 32'(bus.out_rd), 32'(tbl[i].e_rd));
            checkOutput($sformatf("row%0d out_pc", i), bus.out_pc, tbl[i].e_pc);
            checkOutput($sformatf("row%0d out_mask", i), 32'(bus.out_mask), 32'(tbl[i].e_mask));
            checkOutput($sformatf("row%0d stall", i), 32'(bus.stall_cycles), 32'(tbl[i].e_st));
        end

        // Release leftovers: scalar 1/10/12 and vector 9
        applyStimulus(0, 0, 0, 0, 0, 1, 5'd1, 1, 5'd9, 0); tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 5'd10, 0, 5'd0, 0); tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 5'd12, 0, 5'd0, 0); tick();

        // Flush drops held instruction and cancels its issue
        applyStimulus(1, mk(20,0,0,0), 32'h200, F_RW, 0, 0, 0, 0, 0, 0); tick();
        checkOutput("flush pre out_valid", 32'(bus.out_valid), 1);
        checkOutput("flush pre out_rd", 32'(bus.out_rd), 20);
        idle(1'b1, 1'b1); tick();
        checkOutput("flush out_valid", 32'(bus.out_valid), 0);
        applyStimulus(1, mk(21,20,0,0), 32'h204, F_R1|F_RW, 1, 0, 0, 0, 0, 0); #1;
        checkOutput("flush no sb set in_ready", 32'(bus.in_ready), 1);
        tick();
        checkOutput("post flush load out_rd", 32'(bus.out_rd), 21);
        applyStimulus(1, mk(22,0,0,0), 32'h208, F_RW, 1, 0, 0, 0, 0, 1); tick();
        checkOutput("flush inhibits load", 32'(bus.out_valid), 0);
        applyStimulus(1, mk(23,21,22,0), 32'h20C, F_R1|F_R2|F_RW, 1, 0, 0, 0, 0, 0); #1;
        checkOutput("flush cancel issue in_ready", 32'(bus.in_ready), 1);
        tick();
        checkOutput("load r23 out_pc", bus.out_pc, 32'h20C);
        idle(1'b1, 1'b0); tick();

        // Long hazard on r23 saturates the stall counter
        applyStimulus(1, mk(24,23,0,0), 32'h210, F_R1|F_RW, 1, 0, 0, 0, 0, 0); tick();
        checkOutput("stall increments", 32'(bus.stall_cycles), 7 + SO);
        repeat (19) tick();
        checkOutput("stall saturated", 32'(bus.stall_cycles), 15);
        checkOutput("stall in_ready", 32'(bus.in_ready), 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 5'd23, 0, 5'd0, 0); tick();
        idle(1'b1, 1'b0); tick();

        // Issue set and writeback clear on the same index: set wins
        applyStimulus(1, mk(5,0,0,0), 32'h300, F_RW, 0, 0, 0, 0, 0, 0); tick();
        applyStimulus(0, 0, 0, 0, 1, 1, 5'd5, 0, 5'd0, 0); tick();
        checkOutput("set-wins out_valid", 32'(bus.out_valid), 0);
        applyStimulus(1, mk(6,5,0,0), 32'h304, F_R1|F_RW, 1, 0, 0, 0, 0, 0); #1;
        checkOutput("set-wins r5 busy", 32'(bus.in_ready), 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 5'd5, 0, 5'd0, 0); tick();
        applyStimulus(1, mk(6,5,0,0), 32'h304, F_R1|F_RW, 1, 0, 0, 0, 0, 0); #1;
        checkOutput("r5 released in_ready", 32'(bus.in_ready), 1);
        tick();
        checkOutput("r5 released out_rd", 32'(bus.out_rd), 6);
        idle(1'b1, 1'b0); tick();

        // Halt latches until reset; flush does not clear it
        applyStimulus(1, mk(0,0,0,0), 32'h400, F_HT, 0, 0, 0, 0, 0, 0); tick();
        checkOutput("halt held not yet halted", 32'(bus.halted), 0);
        idle(1'b1, 1'b0); tick();
        checkOutput("halt issued", 32'(bus.halted), 1);
        applyStimulus(1, mk(7,0,0,0), 32'h404, F_RW, 1, 0, 0, 0, 0, 0); #1;
        checkOutput("halted in_ready", 32'(bus.in_ready), 0);
        tick();
        checkOutput("halted no load", 32'(bus.out_valid), 0);
        idle(1'b1, 1'b1); tick();
        checkOutput("halted after flush", 32'(bus.halted), 1);
        rst = 1'b1;
        idle(1'b0, 1'b0); tick();
        rst = 1'b0;
        checkOutput("rst clears halted", 32'(bus.halted), 0);
        checkOutput("rst clears stall", 32'(bus.stall_cycles), 0);
        applyStimulus(1, mk(8,0,0,0), 32'h500, F_RW, 1, 0, 0, 0, 0, 0); #1;
        checkOutput("rst in_ready", 32'(bus.in_ready), 1);
        tick();
        checkOutput("post rst load out_rd", 32'(bus.out_rd), 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Registered decode/issue stage between fetch and execute.
- Takes a 32-bit instruction plus the control-unit read/write flags for it.
- Tracks pending scalar and vector register writes in parametrised scoreboards and stalls on RAW/WAW hazards.
- Presents one decoded instruction per cycle to execute over a valid/ready handshake; adds halt latching, flush, and a saturating stall counter.

Parameters:
- NUM_SREG, 32, number of scalar registers; index width SIDX_W = $clog2(NUM_SREG)
- NUM_VREG, 32, number of vector registers; index width VIDX_W = $clog2(NUM_VREG)
- MASK_W, 4, lane mask width taken from inst[MASK_W-1:0]
- LINK_REG, NUM_SREG-1, scalar destination forced when store_pc=1
- STALL_CNT_W, 32, width of stall counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  stage accepts instruction this cycle
- in_inst  in  32  instruction; rd=[24:20], rs1=[19:15], rs2=[14:10], mask=[MASK_W-1:0]
- in_pc  in  32  instruction PC
- in_r_read1, in_r_read2, in_v_read1, in_v_read2  in  1 each  source-use flags
- in_reg_wr, in_vec_wr, in_store_pc, in_halt  in  1 each  dest/control flags
- out_valid  out  1  decoded instruction held
- out_ready  in  1  execute accepts
- out_inst, out_pc  out  32  registered copies
- out_rd  out  SIDX_W  resolved scalar dest (LINK_REG if store_pc)
- out_mask  out  MASK_W  lane mask
- out_reg_wr, out_vec_wr, out_halt  out  1 each  registered flags
- swb_valid  in  1 / swb_idx  in  SIDX_W  scalar writeback completes
- vwb_valid  in  1 / vwb_idx  in  VIDX_W  vector writeback completes
- flush  in  1  discard held instruction
- halted  out  1  halt issued; fetch frozen
- stall_cycles  out  STALL_CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset:
  - out_valid=0; all out_* registers=0.
  - Both scoreboards cleared; halted=0; stall_cycles=0.
  - in_ready is driven purely by the expression below, so it is 1 after reset.
- Sources (only when the flag is set):
  - Scalar: rs1 (r_read1), rs2 (r_read2).
  - Vector: rs2 field (v_read1), rs1 field (v_read2), matching the vector field mapping.
  - Dest: scalar rd (or LINK_REG) if reg_wr; vector rd if vec_wr; both may be set.
- Hazard:
  - A used source or dest index is busy in its scoreboard, OR
  - It equals the dest of a valid output-register instruction of the same class.
- in_ready = !halted & !hazard & (!out_valid | out_ready).
- Load: on in_valid & in_ready, the output register captures the instruction next cycle; latency 1.
- Issue: on out_valid & out_ready, set the scoreboard bits for that instruction's dests. Clear out_valid unless a new load occurs the same cycle.
- Writeback: swb_valid/vwb_valid clear the indexed bit next cycle. If a set and clear hit the same index in the same cycle, the set wins.
- Halt: issuing an instruction with halt=1 sets halted on that edge. halted stays 1 until rst; flush does not clear it.
- Flush:
  - Drops the held instruction (out_valid=0) and inhibits a load that cycle.
  - Scoreboard is untouched, because bits are only set at issue.
  - Flush and issue in the same cycle: the issue is cancelled (execute must also honour flush).
- Stall counter: increments each cycle with in_valid & hazard & !halted; saturates at all-ones, with no wrap.
- Writeback to an idle bit: no effect, no error.

Optional Feature:
- SCOREBOARD_BYPASS_EN defined: the hazard check ignores a scoreboard bit being cleared by swb/vwb that same cycle, so a dependent instruction loads in the writeback cycle.
- Undefined: the check uses the registered bit only, giving one extra stall cycle after writeback.

Test Plan:
- Reset, then in_valid with addi r3,r1 (reg_wr, r_read1) and out_ready=1 -> out_valid=1, out_rd=3 next cycle; scoreboard bit 3 set after issue.
- Issue writes r3, then an instruction reading r3 -> in_ready=0 and stall_cycles increments each cycle. swb_idx=3 pulse -> load one cycle later (same cycle with SCOREBOARD_BYPASS_EN).
- jal with store_pc=1, rd field=5 -> out_rd=31; r31 stays busy until swb_idx=31.
- out_ready=0 for 3 cycles with the register full -> in_ready=0 and outputs stable; out_ready=1 -> back-to-back loads resume.
- Issue halt -> halted=1 and in_ready=0 permanently; flush leaves halted=1; rst -> halted=0.
- Flush while out_valid=1 and out_ready=1 -> out_valid=0 and no scoreboard bit set; stall_cycles forced via a long hazard saturates at 2^STALL_CNT_W-1 (test with STALL_CNT_W=4 -> 15).
